// File: rtl/inst_stream_encoder.sv
// RV32I request-to-instruction encoder that streams encoded words into IMEM.
// One request per cycle; the word appears on the write port the cycle after acceptance.
module inst_stream_encoder #(
   parameter int          IMEM_AWIDTH = 14,
   parameter int unsigned BASE_ADDR   = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   finish,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [3:0]             req_class,
   input  logic [2:0]             req_funct3,
   input  logic                   req_bit30,
   input  logic [4:0]             req_rd,
   input  logic [4:0]             req_rs1,
   input  logic [4:0]             req_rs2,
   input  logic [31:0]            req_imm,
   output logic [3:0]             imem_we,
   output logic [IMEM_AWIDTH-1:0] imem_addr,
   output logic [31:0]            imem_din,
   output logic                   busy,
   output logic                   full,
   output logic                   done,
   output logic                   err,
   output logic [IMEM_AWIDTH:0]   word_count
);

   localparam logic [IMEM_AWIDTH-1:0] L_BASE = IMEM_AWIDTH'(BASE_ADDR);
   localparam logic [IMEM_AWIDTH-1:0] L_LAST = '1;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FULL,
      S_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [IMEM_AWIDTH-1:0] r_ptr;
   logic [IMEM_AWIDTH:0]   r_count;
   logic                   r_err;
   logic                   r_we;
   logic [IMEM_AWIDTH-1:0] r_addr;
   logic [31:0]            r_din;

   logic                   w_ready;
   logic                   w_accept;
   logic                   w_class_ok;
   logic                   w_misalign;
   logic                   w_write;
   logic [IMEM_AWIDTH-1:0] w_wr_addr;
   logic                   w_r_bit30;
   logic [31:0]            w_word;

   assign w_ready    = (r_state == S_LOAD) & ~start & ~finish;
   assign w_accept   = req_valid & w_ready;
   assign w_class_ok = (req_class <= 4'd8);
   assign w_misalign = ((req_class == 4'd2) | (req_class == 4'd4)) & req_imm[0];
   assign w_write    = w_accept & w_class_ok;
   // ptr only advances when the previous write retires, so a write still in flight
   // already owns r_ptr and the new one takes the slot after it.
   assign w_wr_addr  = r_ptr + {{(IMEM_AWIDTH-1){1'b0}}, r_we};
   assign w_r_bit30  = req_bit30 & ((req_funct3 == 3'b000) | (req_funct3 == 3'b101));

   always_comb begin
      w_word = '0;
      case (req_class)
         4'd0: w_word = {req_imm[31:12], req_rd, OP_LUI};
         4'd1: w_word = {req_imm[31:12], req_rd, OP_AUIPC};
         4'd2: w_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
         4'd3: w_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
         4'd4: w_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                         req_imm[4:1], req_imm[11], OP_BRANCH};
         4'd5: w_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
         4'd6: w_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_STORE};
         4'd7: w_word = {1'b0, w_r_bit30, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
         4'd8: begin
            if (req_funct3 == 3'b001)
               w_word = {7'b0, req_imm[4:0], req_rs1, req_funct3, req_rd, OP_I};
            else if (req_funct3 == 3'b101)
               w_word = {1'b0, req_bit30, 5'b0, req_imm[4:0], req_rs1, req_funct3, req_rd, OP_I};
            else
               w_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_I};
         end
         default: w_word = '0;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      if (start)
         w_state_next = S_LOAD;
      else if (finish && ((r_state == S_LOAD) || (r_state == S_FULL)))
         w_state_next = S_DONE;
      else if (w_write && (w_wr_addr == L_LAST))
         w_state_next = S_FULL;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= L_BASE;
         r_count <= '0;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_din   <= '0;
      end else begin
         r_state <= w_state_next;
         r_we    <= w_write;
         if (w_write) begin
            r_addr <= w_wr_addr;
            r_din  <= w_word;
         end
         if (start) begin
            r_ptr   <= L_BASE;
            r_count <= '0;
            r_err   <= 1'b0;
         end else begin
            if (r_we) begin
               r_count <= r_count + (IMEM_AWIDTH+1)'(1);
               if (r_ptr != L_LAST)
                  r_ptr <= r_ptr + IMEM_AWIDTH'(1);
            end
            if (w_accept && (!w_class_ok || w_misalign))
               r_err <= 1'b1;
         end
      end
   end

   assign req_ready  = w_ready;
   assign imem_we    = {4{r_we}};
   assign imem_addr  = r_addr;
   assign imem_din   = r_din;
   assign busy       = (r_state == S_LOAD);
   assign full       = (r_state == S_FULL);
   assign done       = (r_state == S_DONE);
   assign err        = r_err;
   assign word_count = r_count;

endmodule

// File: tb/tb_inst_stream_encoder.sv
// Bench for inst_stream_encoder: directed vector table, corner sequences, and a
// randomized run checked cycle by cycle against a session-level reference model.
module tb_inst_stream_encoder;

   localparam int AW   = 3;
   localparam int BASE = 0;
   localparam int CAP  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          finish = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [3:0]    req_class = '0;
   logic [2:0]    req_funct3 = '0;
   logic          req_bit30 = 1'b0;
   logic [4:0]    req_rd = '0;
   logic [4:0]    req_rs1 = '0;
   logic [4:0]    req_rs2 = '0;
   logic [31:0]   req_imm = '0;
   logic [3:0]    imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_din;
   logic          busy;
   logic          full;
   logic          done;
   logic          err;
   logic [AW:0]   word_count;

   int n_checks = 0;
   int n_errors = 0;

   inst_stream_encoder #(.IMEM_AWIDTH(AW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
      .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
      .req_funct3(req_funct3), .req_bit30(req_bit30), .req_rd(req_rd),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
      .busy(busy), .full(full), .done(done), .err(err), .word_count(word_count)
   );

   always #5 clk = ~clk;

   // Session-level model: states as plain ints, addresses derived from word counts.
   int          m_state;   // 0 idle, 1 load, 2 full, 3 done
   int          m_acc;     // words accepted for writing this session
   int          m_comp;    // writes that have completed this session
   bit          m_err;
   bit          m_we;
   bit [31:0]   m_addr;
   bit [31:0]   m_din;

   function automatic bit [31:0] ref_word(input int cls, input bit [31:0] f3, b30, rd,
                                          rs1, rs2, imm);
      bit [31:0] w;
      case (cls)
         0: w = (imm & 32'hFFFF_F000) | (rd << 7) | 32'h37;
         1: w = (imm & 32'hFFFF_F000) | (rd << 7) | 32'h17;
         2: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
         3: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
         4: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) |
                (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) |
                (((imm >> 11) & 1) << 7) | 32'h63;
         5: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
         6: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                ((imm & 32'h1F) << 7) | 32'h23;
         7: w = (((b30 != 0) && (f3 == 0 || f3 == 5)) ? 32'h4000_0000 : 32'h0) |
                (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
         8: begin
            if (f3 == 1)
               w = ((imm & 32'h1F) << 20);
            else if (f3 == 5)
               w = ((b30 != 0) ? 32'h4000_0000 : 32'h0) | ((imm & 32'h1F) << 20);
            else
               w = ((imm & 32'hFFF) << 20);
            w = w | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         end
         default: w = 32'h0;
      endcase
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_acc = 0; m_comp = 0; m_err = 0; m_we = 0; m_addr = 0; m_din = 0;
   endtask

   function automatic bit model_ready();
      return (m_state == 1) && !start && !finish;
   endfunction

   task automatic model_edge();
      bit acc = model_ready() && req_valid;
      bit nwe = 0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_we) m_comp++;
      if (start) begin
         m_state = 1; m_acc = 0; m_comp = 0; m_err = 0;
      end else if (finish && (m_state == 1 || m_state == 2)) begin
         m_state = 3;
      end else if (acc) begin
         if (req_class > 8) begin
            m_err = 1;
         end else begin
            nwe    = 1;
            m_addr = BASE + m_acc;
            m_din  = ref_word(req_class, req_funct3, req_bit30, req_rd, req_rs1, req_rs2, req_imm);
            m_acc++;
            if ((req_class == 2 || req_class == 4) && req_imm[0]) m_err = 1;
            if (BASE + m_acc == CAP) m_state = 2;
         end
      end
      m_we = nwe;
   endtask

   task automatic check_outputs();
      check("we", imem_we, m_we ? 4'hF : 4'h0);
      check("addr", imem_addr, m_addr);
      check("din", imem_din, m_din);
      check("busy", busy, m_state == 1);
      check("full", full, m_state == 2);
      check("done", done, m_state == 3);
      check("err", err, m_err);
      check("word_count", word_count, m_comp);
   endtask

   // Inputs are already set; check ready, take one edge, check outputs.
   task automatic cyc();
      #1;
      check("ready", req_ready, model_ready());
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic set_req(input logic [3:0] c, input logic [2:0] f3, input logic b30,
                          input logic [4:0] rd, rs1, rs2, input logic [31:0] imm);
      req_class = c; req_funct3 = f3; req_bit30 = b30;
      req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
   endtask

   typedef struct {
      bit          new_s;
      logic [3:0]  cls;
      logic [2:0]  f3;
      logic        b30;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      bit          wr;
      logic [31:0] word;
      logic [31:0] addr;
      bit          err;
      int          cnt;
   } vec_t;

   localparam int NV = 15;
   vec_t tbl [NV];

   initial begin
      tbl[0]  = '{1, 4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,         1, 32'h0050_0093, 0, 0, 1};
      tbl[1]  = '{1, 4'd0, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 1, 32'h1234_5137, 0, 0, 1};
      tbl[2]  = '{0, 4'd7, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,         1, 32'h4020_81B3, 1, 0, 2};
      tbl[3]  = '{1, 4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1, 32'hFE00_0EE3, 0, 0, 1};
      tbl[4]  = '{0, 4'd2, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,         1, 32'h0080_00EF, 1, 0, 2};
      tbl[5]  = '{0, 4'd6, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         1, 32'h0020_A423, 2, 0, 3};
      tbl[6]  = '{1, 4'd8, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3,         1, 32'h4033_5293, 0, 0, 1};
      tbl[7]  = '{0, 4'd8, 3'd1, 1'b1, 5'd1, 5'd1, 5'd0, 32'd2,         1, 32'h0020_9093, 1, 0, 2};
      tbl[8]  = '{0, 4'd7, 3'd7, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,         1, 32'h0020_F1B3, 2, 0, 3};
      tbl[9]  = '{0, 4'd3, 3'd3, 1'b0, 5'd1, 5'd5, 5'd0, 32'd4,         1, 32'h0042_80E7, 3, 0, 4};
      tbl[10] = '{0, 4'd5, 3'd2, 1'b0, 5'd4, 5'd2, 5'd0, 32'hFFFF_FFF8, 1, 32'hFF81_2203, 4, 0, 5};
      tbl[11] = '{0, 4'd1, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'hABCD_E123, 1, 32'hABCD_E397, 5, 0, 6};
      tbl[12] = '{1, 4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,        0, 32'h0,         0, 1, 0};
      tbl[13] = '{1, 4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3,         1, 32'h0000_0163, 0, 1, 1};
      tbl[14] = '{1, 4'd2, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd5,         1, 32'h0040_006F, 0, 1, 1};

      // Reset state
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      model_reset();
      #1;
      check_outputs();
      rst_n = 1'b1;
      cyc();

      // Directed vectors
      for (int i = 0; i < NV; i++) begin
         if (tbl[i].new_s) begin
            start = 1'b1; req_valid = 1'b0;
            cyc();
            start = 1'b0;
         end
         set_req(tbl[i].cls, tbl[i].f3, tbl[i].b30, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
         req_valid = 1'b1;
         cyc();
         check($sformatf("tbl%0d_we", i), imem_we, tbl[i].wr ? 4'hF : 4'h0);
         if (tbl[i].wr) begin
            check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            check($sformatf("tbl%0d_din", i), imem_din, tbl[i].word);
         end
         check($sformatf("tbl%0d_err", i), err, tbl[i].err);
         req_valid = 1'b0;
         cyc();
         check($sformatf("tbl%0d_count", i), word_count, tbl[i].cnt);
         $display("vector %0d: class=%0d word=%h err=%0d count=%0d", i, tbl[i].cls, imem_din, err, word_count);
      end

      // Fill to capacity, then restart
      start = 1'b1;
      cyc();
      start = 1'b0;
      set_req(4'd15, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
      req_valid = 1'b1;
      cyc();
      set_req(4'd8, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd1);
      for (int k = 0; k < CAP; k++) cyc();
      check("full_flag", full, 1);
      check("full_ready", req_ready, 0);
      req_valid = 1'b0;
      cyc();
      check("full_count", word_count, CAP);
      check("full_err", err, 1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("restart_busy", busy, 1);
      check("restart_err", err, 0);
      req_valid = 1'b1;
      cyc();
      check("restart_addr", imem_addr, BASE);
      check("restart_we", imem_we, 4'hF);
      req_valid = 1'b0;
      cyc();
      $display("capacity sequence: count=%0d", word_count);

      // Reset right after an accept, and reset coinciding with a handshake
      start = 1'b1;
      cyc();
      start = 1'b0; req_valid = 1'b1;
      cyc();
      rst_n = 1'b0; req_valid = 1'b0;
      cyc();
      check("rst_after_we", imem_we, 0);
      check("rst_after_count", word_count, 0);
      check("rst_after_busy", busy, 0);
      rst_n = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0; req_valid = 1'b1; rst_n = 1'b0;
      cyc();
      check("rst_same_we", imem_we, 0);
      check("rst_same_busy", busy, 0);
      rst_n = 1'b1; req_valid = 1'b0;
      finish = 1'b1;
      cyc();
      check("finish_idle", done, 0);
      finish = 1'b0;
      $display("reset sequence: we=%h busy=%0d", imem_we, busy);

      // start + finish together; request in that cycle is not taken
      start = 1'b1;
      cyc();
      finish = 1'b1; req_valid = 1'b1;
      #1;
      check("prio_ready", req_ready, 0);
      cyc();
      check("prio_busy", busy, 1);
      check("prio_we", imem_we, 0);
      start = 1'b0; req_valid = 1'b0;
      cyc();
      check("finish_load", done, 1);
      cyc();
      check("finish_done", done, 1);
      finish = 1'b0;
      $display("priority sequence: done=%0d", done);

      // Randomized run against the model
      for (int n = 0; n < 3000; n++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         start     = ($urandom_range(0, 29) == 0);
         finish    = ($urandom_range(0, 39) == 0);
         req_valid = ($urandom_range(0, 9) < 7);
         set_req(($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)),
                 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 ($urandom_range(0, 3) == 0) ? ($urandom | 32'd1) : $urandom);
         cyc();
      end
      rst_n = 1'b1; start = 1'b0; finish = 1'b0; req_valid = 1'b0;
      cyc();
      $display("random run: 3000 cycles");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
